// File: rtl/reduce_nxw_pipe.sv
// rtl/reduce_nxw_pipe.sv - pipelined N x W bitwise reduction with valid/ready stream
//
// Purpose:
//   Reduces N operands of W bits each, bit by bit, with OR / AND / XOR / NOR
//   selected per beat. The reduction is a FANIN-ary tree with one register
//   stage per tree level, so the latency is S = ceil(log_FANIN(N)) cycles (min 1).
//   The whole pipe advances as a unit; empty slots (bubbles) shift along too.
//
// Ports:
//   CLK        in   1    clock, rising edge
//   RESET      in   1    synchronous active-high reset, overrides CE
//   CE         in   1    clock enable; 0 freezes all state
//   I          in   N*W  operands, operand k = I[k*W +: W]
//   op         in   2    00 OR, 01 AND, 10 XOR, 11 NOR
//   in_valid   in   1    I/op valid
//   in_ready   out  1    block accepts I/op this cycle
//   O          out  W    reduction result (registered)
//   out_valid  out  1    O valid
//   out_ready  in   1    downstream accepts O
//   busy       out  1    any stage holds a valid beat

module reduce_nxw_pipe #(
  parameter int N     = 8,
  parameter int W     = 4,
  parameter int FANIN = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic [N*W-1:0]   I,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     O,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  // Number of partials present after s tree levels.
  function automatic int cnt_at(input int s);
    int c;
    c = N;
    for (int k = 0; k < s; k++) c = (c + FANIN - 1) / FANIN;
    return c;
  endfunction

  function automatic int calc_depth();
    int c;
    int d;
    c = N;
    d = 0;
    for (int k = 0; k < 64; k++) begin
      if (c > 1) begin
        c = (c + FANIN - 1) / FANIN;
        d = d + 1;
      end
    end
    if (d < 1) d = 1;
    return d;
  endfunction

  localparam int S = calc_depth();

  logic [S-1:0] w_vld;
  logic         w_advance;

  // Output register is the last stage, so a held result stalls everything.
  assign w_advance = CE & (~out_valid | out_ready);
  assign in_ready  = w_advance;
  assign out_valid = w_vld[S-1];
  assign busy      = |w_vld;

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int CIN  = cnt_at(s);
    localparam int COUT = cnt_at(s + 1);

    logic [CIN*W-1:0]        w_in;
    logic [1:0]              w_op;
    logic                    w_vin;
    logic [W-1:0]            w_id;
    logic [COUT*FANIN*W-1:0] w_pad;
    logic [W-1:0]            w_acc;
    logic [COUT*W-1:0]       w_red;
    logic [COUT*W-1:0]       r_data;
    logic                    r_vld;

    if (s == 0) begin : g_src
      assign w_in  = I;
      assign w_op  = op;
      assign w_vin = in_valid;
    end else begin : g_src
      assign w_in  = g_stage[s-1].r_data;
      assign w_op  = g_stage[s-1].g_op.r_op;
      assign w_vin = g_stage[s-1].r_vld;
    end

    // Identity element fills the short last group: all-ones only for AND.
    assign w_id = (w_op == 2'b01) ? {W{1'b1}} : {W{1'b0}};

    always_comb begin
      w_pad = {(COUT*FANIN){w_id}};
      w_pad[CIN*W-1:0] = w_in;
      w_red = '0;
      w_acc = '0;
      for (int g = 0; g < COUT; g++) begin
        w_acc = w_id;
        for (int j = 0; j < FANIN; j++) begin
          case (w_op)
            2'b01:   w_acc = w_acc & w_pad[(g*FANIN+j)*W +: W];
            2'b10:   w_acc = w_acc ^ w_pad[(g*FANIN+j)*W +: W];
            default: w_acc = w_acc | w_pad[(g*FANIN+j)*W +: W];
          endcase
        end
        w_red[g*W +: W] = w_acc;
      end
      // NOR runs as an OR tree; invert only on the way into the output register.
      if ((s == S - 1) && (w_op == 2'b11)) w_red = ~w_red;
    end

    always_ff @(posedge CLK) begin
      if (RESET) begin
        r_data <= '0;
        r_vld  <= 1'b0;
      end else if (w_advance) begin
        r_data <= w_red;
        r_vld  <= w_vin;
      end
    end

    // The op code only needs to travel to stages that still reduce.
    if (s < S - 1) begin : g_op
      logic [1:0] r_op;
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_op <= 2'b00;
        end else if (w_advance) begin
          r_op <= w_op;
        end
      end
    end

    assign w_vld[s] = r_vld;
  end

  assign O = g_stage[S-1].r_data;

endmodule
